// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Round-robin arbiter sharing the single register-file write port
//            among NREQ requesters (ALU writeback, memory load, immediate
//            load, link address). At most one write commits per cycle; each
//            requester sees a one-cycle ack pulse when its write is issued.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH    register data width in bits (default 8)
//   NREQ     number of requesters, legal range 2..8 (default 4)
// Ports:
//   clk       in   1            rising-edge clock
//   reset     in   1            synchronous, active-high reset
//   req       in   NREQ         per-requester write request
//   req_addr  in   3*NREQ       destination register of requester i at [3i+2:3i]
//   req_data  in   WIDTH*NREQ   write data of requester i at [WIDTH*i +: WIDTH]
//   ack       out  NREQ         one-hot grant/completion pulse
//   wr_en     out  1            register-file write strobe (gates the decoder)
//   wr_sel    out  3            destination select to the 3-to-8 decoder
//   wr_data   out  WIDTH        data to the register file
//   busy      out  1            any request pending or a write in progress
// Build option:
//   R0_PROTECT_EN  when defined, a grant to register 0 is acked but the write
//                  strobe is suppressed, keeping register 0 hardwired to zero.
// ============================================================================
module regfile_write_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [3*NREQ-1:0]     req_addr,
    input  logic [WIDTH*NREQ-1:0] req_data,
    output logic [NREQ-1:0]       ack,
    output logic                  wr_en,
    output logic [2:0]            wr_sel,
    output logic [WIDTH-1:0]      wr_data,
    output logic                  busy
);

    localparam int            PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] C_LAST = PW'(NREQ - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t            state_q,   state_d;
    logic [NREQ-1:0]   ack_q,     ack_d;
    logic [2:0]        wr_sel_q,  wr_sel_d;
    logic [WIDTH-1:0]  wr_data_q, wr_data_d;
    logic [PW-1:0]     rr_ptr_q,  rr_ptr_d;

    logic [NREQ-1:0]   eligible;
    logic              found;
    logic [PW-1:0]     gnt;
    logic [2:0]        gnt_addr;
    logic [WIDTH-1:0]  gnt_data;

    // Grant search and next-state computation.
    always_comb begin
        // The requester acked this cycle is still holding req (it only sees
        // the ack now), so masking it prevents a double grant.
        eligible = req & ~ack_q;

        // First eligible requester at or above rr_ptr, wrapping modulo NREQ.
        found = 1'b0;
        gnt   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && eligible[(int'(rr_ptr_q) + k) % NREQ]) begin
                found = 1'b1;
                gnt   = PW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end

        gnt_addr = req_addr[3*gnt +: 3];
        gnt_data = req_data[WIDTH*gnt +: WIDTH];

        state_d   = IDLE;
        ack_d     = '0;
        wr_sel_d  = wr_sel_q;   // select/data hold their last values when idle
        wr_data_d = wr_data_q;
        rr_ptr_d  = rr_ptr_q;

        if (found) begin
            ack_d[gnt] = 1'b1;
            wr_sel_d   = gnt_addr;
            wr_data_d  = gnt_data;
            rr_ptr_d   = (gnt == C_LAST) ? '0 : gnt + 1'b1;
            state_d    = WRITE;
`ifdef R0_PROTECT_EN
            // Register 0 is hardwired to zero: ack the requester but never
            // commit the write, so the FSM stays out of WRITE.
            if (gnt_addr == 3'd0) begin
                state_d = IDLE;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ack_q     <= '0;
            wr_sel_q  <= '0;
            wr_data_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            wr_sel_q  <= wr_sel_d;
            wr_data_q <= wr_data_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign ack     = ack_q;
    assign wr_en   = (state_q == WRITE);
    assign wr_sel  = wr_sel_q;
    assign wr_data = wr_data_q;
    assign busy    = (|req) | wr_en;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Directed self-checking bench for regfile_write_arbiter
//            (WIDTH=8, NREQ=4) with hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [3*NREQ-1:0]     req_addr;
    logic [WIDTH*NREQ-1:0] req_data;
    logic [NREQ-1:0]       ack;
    logic                  wr_en;
    logic [2:0]            wr_sel;
    logic [WIDTH-1:0]      wr_data;
    logic                  busy;

    int n_vec = 0;
    int n_err = 0;
    bit started = 1'b0;

    regfile_write_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .ack      (ack),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] e_ack,
                              input logic e_en, input logic [2:0] e_sel,
                              input logic [7:0] e_data);
        chk({tag, ".ack"},  32'(ack),     32'(e_ack));
        chk({tag, ".en"},   32'(wr_en),   32'(e_en));
        chk({tag, ".sel"},  32'(wr_sel),  32'(e_sel));
        chk({tag, ".data"}, 32'(wr_data), 32'(e_data));
    endtask

    // Structural invariants, checked every cycle once reset has been applied.
    always @(negedge clk) begin
        if (started) begin
            chk("inv.onehot", 32'($countones(ack) <= 1), 32'd1);
`ifndef R0_PROTECT_EN
            chk("inv.en_eq_or_ack", 32'(wr_en), 32'(|ack));
`endif
        end
    end

    initial begin
        reset    = 1'b1;
        req      = 4'b1111;
        // requesters 0..3 target registers 1..4 with data 11,22,33,44
        req_addr = {3'd4, 3'd3, 3'd2, 3'd1};
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};

        // ---- reset held two cycles with all requests high
        tick();
        tick();
        started = 1'b1;
        expect_out("reset", 4'b0000, 1'b0, 3'd0, 8'h00);
        chk("reset.busy", 32'(busy), 32'd1);

        // ---- round robin with all four held: 0,1,2,3,0
        reset = 1'b0;
        tick(); expect_out("rr0", 4'b0001, 1'b1, 3'd1, 8'h11);
        tick(); expect_out("rr1", 4'b0010, 1'b1, 3'd2, 8'h22);
        tick(); expect_out("rr2", 4'b0100, 1'b1, 3'd3, 8'h33);
        tick(); expect_out("rr3", 4'b1000, 1'b1, 3'd4, 8'h44);
        tick(); expect_out("rr4", 4'b0001, 1'b1, 3'd1, 8'h11);   // rr_ptr -> 1

        // ---- no requests: idle, select/data hold
        req = 4'b0000;
        tick(); expect_out("idle", 4'b0000, 1'b0, 3'd1, 8'h11);
        chk("idle.busy", 32'(busy), 32'd0);

        // ---- single write from requester 2
        req_addr[8:6]   = 3'd5;
        req_data[23:16] = 8'hA5;
        req = 4'b0100;
        tick(); expect_out("single", 4'b0100, 1'b1, 3'd5, 8'hA5); // rr_ptr -> 3
        req = 4'b0000;
        tick(); expect_out("single.done", 4'b0000, 1'b0, 3'd5, 8'hA5);

        // ---- one requester holding req: grant every other cycle
        req = 4'b0010;
        tick(); expect_out("hold0", 4'b0010, 1'b1, 3'd2, 8'h22);
        tick(); expect_out("hold1", 4'b0000, 1'b0, 3'd2, 8'h22);
        tick(); expect_out("hold2", 4'b0010, 1'b1, 3'd2, 8'h22);
        tick(); expect_out("hold3", 4'b0000, 1'b0, 3'd2, 8'h22);
        req = 4'b0000;                                            // rr_ptr = 2
        tick();

        // ---- pointer wrap: ptr=2, only 0 and 1 requesting -> 0 then 1
        req = 4'b0011;
        tick(); expect_out("wrap0", 4'b0001, 1'b1, 3'd1, 8'h11);
        req = 4'b0010;
        tick(); expect_out("wrap1", 4'b0010, 1'b1, 3'd2, 8'h22);
        req = 4'b0000;                                            // rr_ptr = 2
        tick();

        // ---- reset during a write to requester 2
        req = 4'b0100;
        tick(); expect_out("rstw.pre", 4'b0100, 1'b1, 3'd5, 8'hA5); // rr_ptr -> 3
        reset = 1'b1;
        tick(); expect_out("rstw.rst", 4'b0000, 1'b0, 3'd0, 8'h00);
        reset = 1'b0;
        // With rr_ptr back at 0, requester 2 wins over 3; a stale ptr of 3
        // would pick requester 3 first.
        req = 4'b1100;
        tick(); expect_out("rstw.regrant", 4'b0100, 1'b1, 3'd5, 8'hA5);
        req = 4'b1000;
        tick(); expect_out("rstw.next", 4'b1000, 1'b1, 3'd4, 8'h44);
        req = 4'b0000;
        tick();

        // ---- write to register 0 from requester 3
        req_addr[11:9]  = 3'd0;
        req_data[31:24] = 8'h5A;
        req = 4'b1000;
        tick();
`ifdef R0_PROTECT_EN
        expect_out("r0", 4'b1000, 1'b0, 3'd0, 8'h5A);
`else
        expect_out("r0", 4'b1000, 1'b1, 3'd0, 8'h5A);
`endif
        req = 4'b0000;
        tick(); expect_out("end", 4'b0000, 1'b0, 3'd0, 8'h5A);
        chk("end.busy", 32'(busy), 32'd0);

        tick();
        started = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
